// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   arb_state_e : arbiter FSM states
//   wb_entry_t  : one buffered D-cache store (address, data, byte strobes)
package mem_arb_pkg;

  // Byte offset inside a 256-bit (32-byte) cache line.
  localparam int unsigned LINE_OFFSET_BITS = 5;

  // Storage widths of a buffered store; the arbiter's ADDR_WIDTH/DATA_WIDTH must not exceed them.
  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StRdResp,
    StWrIssue,
    StWrWait
  } arb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [3:0]           strb;
  } wb_entry_t;

endpackage

// File: rtl/mem_wr_buffer.sv
// Write buffer: synchronous FIFO of D-cache stores.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_push, i_push_entry   : enqueue a store (caller guarantees not full)
//   i_pop                  : dequeue the head (caller guarantees not empty)
//   o_head                 : oldest entry
//   o_count/o_full/o_empty : occupancy, all from registered state
//   i_query_a/b            : line addresses to look up
//   o_match_a/b            : per-entry hit vectors (valid entry in the same line)
module mem_wr_buffer
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  wb_entry_t                i_push_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  input  logic [WB_ADDR_W-1:0]     i_query_a,
  input  logic [WB_ADDR_W-1:0]     i_query_b,
  output logic [DEPTH-1:0]         o_match_a,
  output logic [DEPTH-1:0]         o_match_b
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic [PtrW-1:0]   w_off;
  logic [DEPTH-1:0]  w_valid;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    w_off     = '0;
    w_valid   = '0;
    o_match_a = '0;
    o_match_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off        = PtrW'(i) - r_rptr;
      w_valid[i]   = CntW'(w_off) < r_count;
      o_match_a[i] = w_valid[i] && (r_mem[i].addr[WB_ADDR_W-1:LINE_OFFSET_BITS] ==
                                    i_query_a[WB_ADDR_W-1:LINE_OFFSET_BITS]);
      o_match_b[i] = w_valid[i] && (r_mem[i].addr[WB_ADDR_W-1:LINE_OFFSET_BITS] ==
                                    i_query_b[WB_ADDR_W-1:LINE_OFFSET_BITS]);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = r_count == CntW'(DEPTH);
  assign o_empty = r_count == '0;

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: owns main memory's read and write channels.
//   I-cache / D-cache refills  : i_*_req + address in, done pulse + 256-bit line out
//   D-cache stores             : valid/ready into a write buffer, drained one word at a time
//   Memory read channel        : o_mem_read_req/address, i_mem_read_done/i_cache_line
//   Memory write channel       : o_mem_write_valid/data/address/o_write_strobe, i_mem_write_done
// One memory transaction at a time; a refill hitting a line with a buffered store drains first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 256,
  parameter int unsigned WB_DEPTH         = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ic_req,
  input  logic [ADDR_WIDTH-1:0]       i_ic_addr,
  output logic                        o_ic_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_ic_line,
  input  logic                        i_dc_rd_req,
  input  logic [ADDR_WIDTH-1:0]       i_dc_rd_addr,
  output logic                        o_dc_rd_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_dc_line,
  input  logic                        i_dc_wr_valid,
  input  logic [ADDR_WIDTH-1:0]       i_dc_wr_addr,
  input  logic [DATA_WIDTH-1:0]       i_dc_wr_data,
  input  logic [3:0]                  i_dc_wr_strb,
  output logic                        o_dc_wr_ready,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  output logic                        o_mem_read_req,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
  output logic                        o_mem_write_valid,
  output logic [DATA_WIDTH-1:0]       o_mem_write_data,
  output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
  output logic [7:0]                  o_write_strobe,
  input  logic                        i_mem_write_done
);

  localparam int unsigned CntW = $clog2(WB_DEPTH) + 1;

  arb_state_e                  r_state, w_state_d;
  logic                        r_grant_dc, w_grant_dc_d;  // current read belongs to D-cache
  logic                        r_rr_dc, w_rr_dc_d;        // D-cache wins the next tie
  logic [ADDR_WIDTH-1:0]       r_rd_addr, w_rd_addr_d;
  logic [CACHE_LINE_WIDTH-1:0] r_ic_line, r_dc_line;

  wb_entry_t                   w_push_entry, w_head;
  logic [CntW-1:0]             w_count;
  logic                        w_full, w_empty, w_push, w_pop, w_hazard, w_wr_active;
  logic [WB_DEPTH-1:0]         w_match_ic, w_match_dc;

  assign o_dc_wr_ready = w_count < CntW'(WB_DEPTH);
  assign w_push        = i_dc_wr_valid && o_dc_wr_ready;
  assign w_pop         = (r_state == StWrWait) && i_mem_write_done;

  assign w_push_entry.addr = WB_ADDR_W'(i_dc_wr_addr);
  assign w_push_entry.data = WB_DATA_W'(i_dc_wr_data);
  assign w_push_entry.strb = i_dc_wr_strb;

  mem_wr_buffer #(
    .DEPTH (WB_DEPTH)
  ) u_wr_buffer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .i_query_a    (WB_ADDR_W'(i_ic_addr)),
    .i_query_b    (WB_ADDR_W'(i_dc_rd_addr)),
    .o_match_a    (w_match_ic),
    .o_match_b    (w_match_dc)
  );

  // A pending refill must not overtake a buffered store to the same line.
  assign w_hazard = (i_ic_req && |w_match_ic) || (i_dc_rd_req && |w_match_dc);

  always_comb begin
    w_state_d    = r_state;
    w_grant_dc_d = r_grant_dc;
    w_rr_dc_d    = r_rr_dc;
    w_rd_addr_d  = r_rd_addr;
    unique case (r_state)
      StIdle: begin
        if (w_full || w_hazard) begin
          w_state_d = StWrIssue;
        end else if (i_ic_req || i_dc_rd_req) begin
          w_grant_dc_d = i_dc_rd_req && (!i_ic_req || r_rr_dc);
          w_rd_addr_d  = w_grant_dc_d ? i_dc_rd_addr : i_ic_addr;
          w_rr_dc_d    = !w_grant_dc_d;
          w_state_d    = StRdIssue;
        end else if (!w_empty) begin
          w_state_d = StWrIssue;
        end
      end
      StRdIssue: w_state_d = StRdWait;
      StRdWait:  if (i_mem_read_done) w_state_d = StRdResp;
      StRdResp:  w_state_d = StIdle;
      StWrIssue: w_state_d = StWrWait;
      StWrWait:  if (i_mem_write_done) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_grant_dc <= 1'b0;
      r_rr_dc    <= 1'b0;
      r_rd_addr  <= '0;
      r_ic_line  <= '0;
      r_dc_line  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_grant_dc <= w_grant_dc_d;
      r_rr_dc    <= w_rr_dc_d;
      r_rd_addr  <= w_rd_addr_d;
      if (r_state == StRdWait && i_mem_read_done) begin
        if (r_grant_dc) r_dc_line <= i_cache_line;
        else            r_ic_line <= i_cache_line;
      end
    end
  end

  assign o_mem_read_req     = r_state == StRdIssue;
  assign o_mem_read_address = r_rd_addr;
  assign o_ic_done          = (r_state == StRdResp) && !r_grant_dc;
  assign o_dc_rd_done       = (r_state == StRdResp) && r_grant_dc;
  assign o_ic_line          = r_ic_line;
  assign o_dc_line          = r_dc_line;

  // Head entry is shown only while a drain is in flight so idle outputs stay zero.
  assign w_wr_active         = (r_state == StWrIssue) || (r_state == StWrWait);
  assign o_mem_write_valid   = r_state == StWrIssue;
  assign o_mem_write_address = w_wr_active ? ADDR_WIDTH'(w_head.addr) : '0;
  assign o_mem_write_data    = w_wr_active ? DATA_WIDTH'(w_head.data) : '0;
  assign o_write_strobe      = w_wr_active ? {4'b0000, w_head.strb} : 8'h00;

endmodule
